// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - iterative multiply/divide unit with HI/LO registers
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH);

    typedef enum logic [1:0] {IDLE, CALC, FIX} state_t;

    state_t             state;
    state_t             next_state;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] acc;
    logic [WIDTH-1:0]   mag_a;
    logic [WIDTH-1:0]   mag_b;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;

    logic               req;
    logic               accept;
    logic               signed_op;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;
    logic               last;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_next;
    logic [WIDTH:0]     div_trial;
    logic [2*WIDTH-1:0] div_next;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;

    assign req       = (state == IDLE) && start && !flush;
    assign accept    = req && !op[2];
    assign signed_op = !op[0];
    assign abs_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    assign abs_b     = (signed_op && b[WIDTH-1]) ? -b : b;
    assign last      = (cnt == CW'(WIDTH - 1));

    // Multiply: acc = {partial product, remaining multiplier bits}, shifted right each step.
    assign mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_a} : '0);
    assign mul_next = {mul_sum, acc[WIDTH-1:1]};

    // Divide: acc = {remainder, dividend/quotient}, shifted left each step.
    assign div_trial = acc[2*WIDTH-1:WIDTH-1] - {1'b0, mag_b};
    assign div_next  = div_trial[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0}
                                        : {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_q ? -acc : acc;
    assign quo_fix  = neg_q ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    assign rem_fix  = neg_r ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = CALC;
            CALC:    if (flush) next_state = IDLE;
                     else if (last) next_state = FIX;
            FIX:     next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            hi     <= '0;
            lo     <= '0;
            done   <= 1'b0;
            cnt    <= '0;
            acc    <= '0;
            mag_a  <= '0;
            mag_b  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        is_div <= op[1];
                        mag_a  <= abs_a;
                        mag_b  <= abs_b;
                        // Divide by zero keeps an all-ones quotient regardless of signs.
                        neg_q  <= signed_op && (a[WIDTH-1] ^ b[WIDTH-1]) && (!op[1] || (b != '0));
                        neg_r  <= signed_op && a[WIDTH-1];
                        cnt    <= '0;
                        acc    <= op[1] ? {{WIDTH{1'b0}}, abs_a} : {{WIDTH{1'b0}}, abs_b};
                    end else if (req && op == 3'd4) begin
                        hi <= a;
                    end else if (req && op == 3'd5) begin
                        lo <= a;
                    end
                end
                CALC: begin
                    if (!flush) begin
                        acc <= is_div ? div_next : mul_next;
                        cnt <= cnt + CW'(1);
                    end
                end
                FIX: begin
                    if (!flush) begin
                        if (is_div) begin
                            lo <= quo_fix;
                            hi <= rem_fix;
                        end else begin
                            {hi, lo} <= prod_fix;
                        end
                        done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
